// File: rtl/res_unit_sequencer_pkg.sv
// rtl/res_unit_sequencer_pkg.sv - shared types and constants for the residual-unit sequencer
package res_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_C1_GO,
        S_C1_WAIT,
        S_C2_GO,
        S_C2_WAIT,
        S_ADD_RUN,
        S_ADD_DRAIN,
        S_NEXT,
        S_FIN
    } state_e;

    localparam logic [1:0] BUF_X  = 2'd0;
    localparam logic [1:0] BUF_T1 = 2'd1;
    localparam logic [1:0] BUF_T2 = 2'd2;

    localparam logic [1:0] K1x1 = 2'd1;
    localparam logic [1:0] K3x3 = 2'd3;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/res_unit_sequencer_add_delay.sv
// rtl/res_unit_sequencer_add_delay.sv - LAT-deep valid+address delay line for in-place add passes
module res_add_delay #(
    parameter int LAT = 2,
    parameter int AW  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          vld_i,
    input  logic [AW-1:0] addr_i,
    output logic          vld_o,
    output logic [AW-1:0] addr_o,
    output logic          pending_o
);

    logic [LAT-1:0] vld_q;
    logic [AW-1:0]  addr_q [LAT];

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) addr_q[i] <= '0;
        end else begin
            vld_q[0]  <= vld_i;
            addr_q[0] <= addr_i;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
        end
    end

    assign vld_o  = vld_q[LAT-1];
    assign addr_o = addr_q[LAT-1];

    // Entries not yet at the output stage; the line is empty next cycle when these are all clear.
    generate
        if (LAT > 1) begin : g_pend
            assign pending_o = |vld_q[LAT-2:0];
        end else begin : g_nopend
            assign pending_o = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/res_unit_sequencer.sv
// rtl/res_unit_sequencer.sv - sequences 1x1 CBS, 3x3 CBS and in-place add through NUM_RES residual units
module res_unit_sequencer
    import res_pkg::*;
#(
    parameter  int D       = 1,
    parameter  int H       = 4,
    parameter  int W       = 4,
    parameter  int NUM_RES = 1,
    parameter  int ADD_LAT = 2,
    localparam int SIZE    = D * H * W,
    localparam int ADDR_W  = clog2_min1(SIZE),
    localparam int WSEL_W  = clog2_min1(2 * NUM_RES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              eng_start,
    output logic [1:0]        eng_ksize,
    output logic              eng_pad,
    output logic [1:0]        eng_src_sel,
    output logic [1:0]        eng_dst_sel,
    output logic [WSEL_W-1:0] eng_wsel,
    input  logic              eng_done,
    output logic              add_rd_en,
    output logic [ADDR_W-1:0] add_rd_addr,
    output logic              add_wr_en,
    output logic [ADDR_W-1:0] add_wr_addr,
    output logic [7:0]        unit_idx
);

    state_e              state_q;
    logic                busy_q, done_q, eng_start_q, pad_q, rd_en_q;
    logic [1:0]          ksize_q, src_q, dst_q;
    logic [WSEL_W-1:0]   wsel_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    logic [7:0]          unit_q, unit_d;
    logic                enter_c1, pend;

    // Both launch paths (fresh start, next unit) enter C1_GO through one shared update.
    assign enter_c1 = (state_q == S_IDLE && start) ||
                      (state_q == S_NEXT && unit_q != 8'(NUM_RES - 1));
    assign unit_d   = (state_q == S_IDLE) ? 8'd0 : unit_q + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            eng_start_q <= 1'b0;
            ksize_q     <= K1x1;
            pad_q       <= 1'b0;
            src_q       <= BUF_X;
            dst_q       <= BUF_T1;
            wsel_q      <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            unit_q      <= 8'd0;
        end else begin
            eng_start_q <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: ;
                S_C1_GO: state_q <= S_C1_WAIT;
                S_C1_WAIT: if (eng_done) begin
                    state_q     <= S_C2_GO;
                    eng_start_q <= 1'b1;
                    ksize_q     <= K3x3;
                    pad_q       <= 1'b1;
                    src_q       <= BUF_T1;
                    dst_q       <= BUF_T2;
                    wsel_q      <= WSEL_W'({unit_q, 1'b1});
                end
                S_C2_GO: state_q <= S_C2_WAIT;
                S_C2_WAIT: if (eng_done) begin
                    state_q   <= S_ADD_RUN;
                    rd_en_q   <= 1'b1;
                    rd_addr_q <= '0;
                end
                S_ADD_RUN: begin
                    if (rd_addr_q == ADDR_W'(SIZE - 1)) begin
                        state_q <= S_ADD_DRAIN;
                        rd_en_q <= 1'b0;
                    end else begin
                        rd_addr_q <= rd_addr_q + 1'b1;
                    end
                end
                S_ADD_DRAIN: if (!pend) state_q <= S_NEXT;
                S_NEXT: if (unit_q == 8'(NUM_RES - 1)) begin
                    state_q <= S_FIN;
                    done_q  <= 1'b1;
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            if (enter_c1) begin
                state_q     <= S_C1_GO;
                busy_q      <= 1'b1;
                unit_q      <= unit_d;
                eng_start_q <= 1'b1;
                ksize_q     <= K1x1;
                pad_q       <= 1'b0;
                src_q       <= BUF_X;
                dst_q       <= BUF_T1;
                wsel_q      <= WSEL_W'({unit_d, 1'b0});
            end
        end
    end

    res_add_delay #(
        .LAT (ADD_LAT),
        .AW  (ADDR_W)
    ) u_delay (
        .clk       (clk),
        .reset     (reset),
        .vld_i     (rd_en_q),
        .addr_i    (rd_addr_q),
        .vld_o     (add_wr_en),
        .addr_o    (add_wr_addr),
        .pending_o (pend)
    );

    assign busy        = busy_q;
    assign done        = done_q;
    assign eng_start   = eng_start_q;
    assign eng_ksize   = ksize_q;
    assign eng_pad     = pad_q;
    assign eng_src_sel = src_q;
    assign eng_dst_sel = dst_q;
    assign eng_wsel    = wsel_q;
    assign add_rd_en   = rd_en_q;
    assign add_rd_addr = rd_addr_q;
    assign unit_idx    = unit_q;

endmodule
